uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART_TX instance between NUM_REQ byte producers using round-robin arbitration. Each producer has a valid/ready byte interface. The block accepts one byte from the winner and launches it with a single-cycle o_TX_DV. It then waits for the transmitter's done pulse before arbitrating again. It sits directly in front of UART_TX, whose i_TX_DV and i_TX_Byte it drives and whose o_TX_Active and o_TX_Done it consumes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 217, UART bit period in clocks; must match the UART_TX instance
TIMEOUT_BITS, 12, watchdog limit in bit periods; limit = TIMEOUT_BITS*CLKS_PER_BIT clocks

Ports:
i_Clock  in  1  system clock, rising edge
i_Rst_L  in  1  asynchronous active-low reset
i_Req_Valid  in  NUM_REQ  per-requester byte valid
i_Req_Byte  in  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k]
i_Req_Last  in  NUM_REQ  end-of-packet flag; only used when UART_ARB_PKT_LOCK_EN is defined
o_Req_Ready  out  NUM_REQ  one-hot accept; handshake = valid & ready
o_Grant  out  NUM_REQ  one-hot owner of the byte in flight
o_TX_DV  out  1  to UART_TX i_TX_DV
o_TX_Byte  out  8  to UART_TX i_TX_Byte
i_TX_Active  in  1  from UART_TX o_TX_Active
i_TX_Done  in  1  from UART_TX o_TX_Done
o_Busy  out  1  high whenever the state is not IDLE
o_Timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (asynchronous, i_Rst_L=0):
  - state=IDLE; o_TX_DV=0; o_TX_Byte=0x00; o_Grant=0; o_Timeout=0; watchdog counter=0.
  - Round-robin pointer is set to last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - Packet lock is cleared.
- IDLE:
  - When any i_Req_Valid=1 and i_TX_Active=0, exactly one o_Req_Ready bit goes high combinationally in the same cycle.
  - The winner is the first valid requester searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - On the handshake: latch the byte into o_TX_Byte, set o_Grant to the winner, set last_grant to the winner, and go to LAUNCH.
  - While i_TX_Active=1, all o_Req_Ready bits stay 0.
- LAUNCH:
  - o_TX_DV=1 for exactly this one cycle; next state is WAIT_DONE.
  - Handshake-to-DV latency is 1 cycle.
- WAIT_DONE:
  - o_Req_Ready=0; the watchdog increments every cycle.
  - On i_TX_Done=1: go to IDLE, clear o_Grant, clear the watchdog.
  - On watchdog == limit-1 with no done: pulse o_Timeout, go to IDLE, clear o_Grant and the packet lock.
  - If i_TX_Done and the watchdog limit occur in the same cycle, done wins and no timeout pulse is issued.
- o_TX_Byte holds its value until the next handshake. It changes only on a handshake.
- i_Req_Byte is sampled only at the handshake. A requester may drop valid before being granted; nothing is latched in that case.
- Back-to-back throughput: one byte per (UART frame + 2 clocks) minimum.
- A reset mid-frame aborts immediately. UART_TX is reset separately by the same i_Rst_L.
- Widths: the watchdog counter is $clog2(TIMEOUT_BITS*CLKS_PER_BIT)+1 bits, and the limit compare is unsigned.

Optional Feature:
UART_ARB_PKT_LOCK_EN.
- Defined:
  - A handshake with i_Req_Last=0 locks arbitration to that requester.
  - While locked, the IDLE state offers ready only to the locked requester; others wait even if valid.
  - The lock releases on a handshake with i_Req_Last=1, on a watchdog timeout, or on reset.
- Undefined:
  - i_Req_Last is ignored, and arbitration is per byte.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_DONE);
  - default CLKS_PER_BIT=217;
  - default TIMEOUT_BITS=12;
  - the function computing the watchdog limit.
- One natural sub-module, uart_rr_pick:
  - purely combinational;
  - inputs are the valid vector, last_grant and a lock mask;
  - outputs are the one-hot winner and an any-valid flag;
  - it is instanced once.

Test Plan:
1. Single producer: requester 0 presents 0xA5 with the others idle. Required: o_Req_Ready[0] high for 1 cycle, then o_TX_DV=1 for exactly one cycle with o_TX_Byte=0xA5. A looped-back UART_RX must report 0xA5.
2. Round-robin fairness: all four requesters continuously valid with bytes 0x10, 0x21, 0x32, 0x43. Required: grant order 0,1,2,3,0,1 and no o_TX_DV while i_TX_Active=1.
3. Priority rotation: requester 2 sends, then requesters 1 and 3 assert valid together. Required: 3 is granted before 1.
4. Watchdog: stub i_TX_Done held at 0. Required: o_Timeout pulses 2604 clocks after LAUNCH, the block returns to IDLE, and the next valid request is accepted.
5. Reset mid-frame: drop i_Rst_L during WAIT_DONE. Required: o_TX_DV=0, o_Grant=0 and o_Busy=0 immediately; after release, requester 0 wins a 4-way contention.
6. Packet lock (UART_ARB_PKT_LOCK_EN defined): requester 0 sends 0x11 (last=0) then 0x22 (last=1) while requester 1 is valid throughout. Required: transmit order 0x11, 0x22, then requester 1's byte. With the macro undefined, the order is 0x11, requester 1's byte, 0x22.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               Holds the arbiter state enum, the default UART timing
//               parameters, and the watchdog limit helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int c_DEF_CLKS_PER_BIT = 217;
  localparam int c_DEF_TIMEOUT_BITS = 12;

  // Watchdog limit in clocks: a frame that has not finished within this
  // many bit periods is considered lost.
  function automatic int wdog_limit(input int timeout_bits, input int clks_per_bit);
    return timeout_bits * clks_per_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Bundle of the producer-side valid/ready byte bus and the
//               UART_TX control/status signals handled by uart_tx_arbiter.
//   slave  modport : the arbiter's view
//   master modport : the environment's view (producers + UART_TX)
//   Signals:
//     i_Req_Valid/i_Req_Byte/i_Req_Last : per-requester byte offers
//     o_Req_Ready                       : one-hot accept
//     o_Grant                           : one-hot owner of byte in flight
//     o_TX_DV/o_TX_Byte                 : to UART_TX
//     i_TX_Active/i_TX_Done             : from UART_TX
//     o_Busy/o_Timeout                  : status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [NUM_REQ*8-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic                 o_Busy;
  logic                 o_Timeout;

  modport slave (
    input  i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout
  );

  modport master (
    output i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout
  );

endinterface

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Searches the masked valid
//               vector starting one past the last grant and returns the
//               first hit as a one-hot winner.
//   i_valid      : request valid vector
//   i_last_grant : index of the previous winner
//   i_lock_mask  : requesters allowed to compete this cycle
//   o_winner     : one-hot winner (zero when nobody competes)
//   o_any_valid  : at least one masked requester is valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  wire logic [NUM_REQ-1:0] i_valid,
  input  wire logic [IDX_W-1:0]   i_last_grant,
  input  wire logic [NUM_REQ-1:0] i_lock_mask,
  output logic      [NUM_REQ-1:0] o_winner,
  output logic                    o_any_valid
);

  logic [NUM_REQ-1:0] w_cand;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

  assign w_cand      = i_valid & i_lock_mask;
  assign o_any_valid = |w_cand;

  // Walk last_grant+1, last_grant+2, ... (mod NUM_REQ); the previous winner
  // is visited last so it only wins again when nobody else is asking.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = IDX_W'((int'(i_last_grant) + off) % NUM_REQ);
      if (!w_found && w_cand[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART_TX between NUM_REQ byte producers with
//               round-robin arbitration. Accepts one byte from the winner,
//               launches it with a one-cycle o_TX_DV, then waits for the
//               transmitter's done pulse (or a watchdog expiry) before
//               arbitrating again.
//   i_Clock : system clock, rising edge
//   i_Rst_L : asynchronous active-low reset
//   bus     : uart_tx_arbiter_if.slave (requester bus + UART_TX signals)
//   Optional build macro UART_ARB_PKT_LOCK_EN: when defined, a handshake
//   with i_Req_Last=0 locks arbitration to that requester until a handshake
//   with i_Req_Last=1, a watchdog timeout or reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = c_DEF_TIMEOUT_BITS
) (
  input wire logic         i_Clock,
  input wire logic         i_Rst_L,
  uart_tx_arbiter_if.slave bus
);

  localparam int c_LIMIT  = wdog_limit(TIMEOUT_BITS, CLKS_PER_BIT);
  localparam int c_WDOG_W = $clog2(c_LIMIT) + 1;
  localparam int c_IDX_W  = $clog2(NUM_REQ);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(c_LIMIT - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_REQ - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [c_IDX_W-1:0]   r_last_grant;
  logic [NUM_REQ-1:0]   r_grant;
  logic [7:0]           r_tx_byte;
  logic [c_WDOG_W-1:0]  r_wdog;

  logic [NUM_REQ-1:0]   w_lock_mask;
  logic [NUM_REQ-1:0]   w_winner;
  logic                 w_any_valid;
  logic                 w_handshake;
  logic                 w_timeout;
  logic [c_IDX_W-1:0]   w_win_idx;
  logic [7:0]           w_win_byte;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_pick (
    .i_valid      (bus.i_Req_Valid),
    .i_last_grant (r_last_grant),
    .i_lock_mask  (w_lock_mask),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  // The winner is always valid, so offering ready to it is the handshake.
  assign w_handshake = (r_state == IDLE) && !bus.i_TX_Active && w_any_valid;

  // Encode the one-hot winner and mux out its byte.
  always_comb begin
    w_win_idx  = '0;
    w_win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner[k]) begin
        w_win_idx  = c_IDX_W'(k);
        w_win_byte = bus.i_Req_Byte[k*8 +: 8];
      end
    end
  end

`ifdef UART_ARB_PKT_LOCK_EN
  logic               r_lock;
  logic [c_IDX_W-1:0] r_lock_idx;
  logic               w_win_last;

  assign w_win_last  = |(w_winner & bus.i_Req_Last);
  assign w_lock_mask = r_lock ? (NUM_REQ'(1) << r_lock_idx) : '1;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_handshake) begin
      r_lock     <= !w_win_last;
      r_lock_idx <= w_win_idx;
    end else if (w_timeout) begin
      r_lock     <= 1'b0;
    end
  end
`else
  assign w_lock_mask = '1;
`endif

  // State register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; done takes precedence over a simultaneous watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_TX_Done) begin
          w_state_nxt = IDLE;
        end else if (r_wdog == c_WDOG_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Byte/grant capture, round-robin pointer and watchdog
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_byte    <= 8'h00;
      r_grant      <= '0;
      r_last_grant <= c_IDX_LAST;
      r_wdog       <= '0;
    end else begin
      if (w_handshake) begin
        r_tx_byte    <= w_win_byte;
        r_grant      <= w_winner;
        r_last_grant <= w_win_idx;
      end
      if (r_state == WAIT_DONE) begin
        if (bus.i_TX_Done || w_timeout) begin
          r_grant <= '0;
          r_wdog  <= '0;
        end else begin
          r_wdog  <= r_wdog + 1'b1;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign bus.o_Req_Ready = w_handshake ? w_winner : '0;
  assign bus.o_Grant     = r_grant;
  assign bus.o_TX_DV     = (r_state == LAUNCH);
  assign bus.o_TX_Byte   = r_tx_byte;
  assign bus.o_Busy      = (r_state != IDLE);
  assign bus.o_Timeout   = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Producers are fed
//               from per-requester queues, a behavioural UART_TX stub
//               answers each launch, and expected (byte, grant) pairs are
//               queued when stimulus is issued and popped at each launch.
//               Expected packet-lock order follows UART_ARB_PKT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 20;
  localparam int LIMIT = 12 * 217;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [7:0]      data;
    logic [NREQ-1:0] grant;
  } exp_t;

  typedef logic [8:0] ent_q_t[$];

  logic clk;
  logic rst_l;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .CLKS_PER_BIT (217),
    .TIMEOUT_BITS (12)
  ) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_l),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t   sb_q[$];
  ent_q_t req_q[NREQ];

  int cyc = 0;
  int hs_cyc = 0;
  int last_dv_cyc = 0;
  int tmo_cyc = 0;
  int tmo_cnt = 0;
  int tx_count = 0;
  int ready_cnt[NREQ];
  bit no_done = 0;
  bit force_active = 0;
  bit in_frame = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Producers: present the head of each queue; pop after a handshake.
  initial begin : producer
    logic [NREQ-1:0]   hs_pend;
    logic [NREQ-1:0]   v_valid;
    logic [NREQ*8-1:0] v_byte;
    logic [NREQ-1:0]   v_last;
    hs_pend = '0;
    bus.i_Req_Valid = '0;
    bus.i_Req_Byte  = '0;
    bus.i_Req_Last  = '0;
    for (int k = 0; k < NREQ; k++) ready_cnt[k] = 0;
    forever begin
      @(negedge clk);
      v_valid = '0;
      v_byte  = '0;
      v_last  = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (hs_pend[k] && req_q[k].size() > 0) void'(req_q[k].pop_front());
        if (req_q[k].size() > 0) begin
          v_valid[k]        = 1'b1;
          v_byte[k*8 +: 8]  = req_q[k][0][7:0];
          v_last[k]         = req_q[k][0][8];
        end
      end
      bus.i_Req_Valid = v_valid;
      bus.i_Req_Byte  = v_byte;
      bus.i_Req_Last  = v_last;
      #1;
      hs_pend = bus.o_Req_Ready & bus.i_Req_Valid;
      if (hs_pend != '0) hs_cyc = cyc;
      for (int k = 0; k < NREQ; k++) if (bus.o_Req_Ready[k]) ready_cnt[k]++;
      if (bus.o_Req_Ready != '0) begin
        checks++;
        if ($countones(bus.o_Req_Ready) != 1) begin
          errors++;
          $display("FAIL ready_onehot: ready=%b, required exactly one bit", bus.o_Req_Ready);
        end
      end
    end
  end

  // Behavioural UART_TX: capture the launch, stay active for FRAME cycles,
  // then pulse done (unless suppressed).
  initial begin : tx_stub
    int   frame_cnt;
    bit   done_d;
    exp_t e;
    frame_cnt = 0;
    bus.i_TX_Active = 1'b0;
    bus.i_TX_Done   = 1'b0;
    forever begin
      @(negedge clk);
      done_d = 1'b0;
      if (!rst_l) begin
        in_frame = 1'b0;
      end else if (in_frame) begin
        if (frame_cnt >= FRAME) begin
          in_frame = 1'b0;
          done_d   = !no_done;
        end else begin
          frame_cnt++;
        end
      end else if (bus.o_TX_DV) begin
        in_frame  = 1'b1;
        frame_cnt = 0;
        tx_count++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: byte=%h grant=%b, required no launch", bus.o_TX_Byte, bus.o_Grant);
        end else begin
          e = sb_q.pop_front();
          if (bus.o_TX_Byte !== e.data) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", bus.o_TX_Byte, e.data);
          end
          checks++;
          if (bus.o_Grant !== e.grant) begin
            errors++;
            $display("FAIL tx_grant: got %b, required %b", bus.o_Grant, e.grant);
          end
          checks++;
          if (cyc - hs_cyc != 1) begin
            errors++;
            $display("FAIL hs_to_dv: got %0d cycles, required 1", cyc - hs_cyc);
          end
        end
      end
      bus.i_TX_Active = in_frame | force_active;
      bus.i_TX_Done   = done_d;
    end
  end

  // Cycle monitor, sampled just after the active edge.
  initial begin : monitor
    bit prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_TX_DV) begin
        last_dv_cyc = cyc;
        checks++;
        if (prev_dv) begin
          errors++;
          $display("FAIL dv_width: o_TX_DV high %0d consecutive cycles, required 1", 2);
        end
        checks++;
        if (bus.i_TX_Active) begin
          errors++;
          $display("FAIL dv_while_active: dv=1 active=%b, required active=0", bus.i_TX_Active);
        end
      end
      if (bus.o_Timeout) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      prev_dv = bus.o_TX_DV;
    end
  end

  task automatic push_req(input int k, input logic [7:0] d, input logic last);
    req_q[k].push_back({last, d});
  endtask

  task automatic expect_tx(input int k, input logic [7:0] d);
    exp_t e;
    e.data  = d;
    e.grant = NREQ'(1) << k;
    sb_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) ready_cnt[k] = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    int pend;
    n = 0;
    forever begin
      pend = 0;
      for (int k = 0; k < NREQ; k++) pend += req_q[k].size();
      if (!(sb_q.size() != 0 || pend != 0 || bus.o_Busy || in_frame || bus.i_TX_Active) || n >= BUDGET) break;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    #3;
    checks += 6;
    if (bus.o_TX_DV !== 1'b0)     begin errors++; $display("FAIL rst_dv: got %b, required 0", bus.o_TX_DV); end
    if (bus.o_TX_Byte !== 8'h00)  begin errors++; $display("FAIL rst_byte: got %h, required 00", bus.o_TX_Byte); end
    if (bus.o_Grant !== '0)       begin errors++; $display("FAIL rst_grant: got %b, required 0", bus.o_Grant); end
    if (bus.o_Busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", bus.o_Busy); end
    if (bus.o_Timeout !== 1'b0)   begin errors++; $display("FAIL rst_timeout: got %b, required 0", bus.o_Timeout); end
    if (bus.o_Req_Ready !== '0)   begin errors++; $display("FAIL rst_ready: got %b, required 0", bus.o_Req_Ready); end
    apply_reset();
    checks++;
    if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b, required 0", bus.o_Busy); end
  endtask

  task automatic test_single();
    apply_reset();
    expect_tx(0, 8'hA5);
    push_req(0, 8'hA5, 1'b1);
    wait_idle("single");
    checks += 2;
    if (ready_cnt[0] != 1) begin errors++; $display("FAIL single_ready: got %0d cycles, required 1", ready_cnt[0]); end
    if (bus.o_TX_Byte !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h, required a5", bus.o_TX_Byte); end
  endtask

  task automatic test_round_robin();
    logic [7:0] b[NREQ];
    b[0] = 8'h10; b[1] = 8'h21; b[2] = 8'h32; b[3] = 8'h43;
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NREQ; k++) begin
        push_req(k, b[k], 1'b1);
        expect_tx(k, b[k]);
      end
    wait_idle("round_robin");
  endtask

  task automatic test_rotation();
    apply_reset();
    expect_tx(2, 8'h2A);
    push_req(2, 8'h2A, 1'b1);
    wait_idle("rotation_a");
    expect_tx(3, 8'hB3);
    expect_tx(1, 8'hB1);
    push_req(1, 8'hB1, 1'b1);
    push_req(3, 8'hB3, 1'b1);
    wait_idle("rotation_b");
  endtask

  task automatic test_ready_blocked();
    apply_reset();
    force_active = 1'b1;
    repeat (2) @(negedge clk);
    push_req(0, 8'h5A, 1'b1);
    expect_tx(0, 8'h5A);
    repeat (5) @(negedge clk);
    #2;
    checks += 3;
    if (bus.o_Req_Ready !== '0)  begin errors++; $display("FAIL blocked_ready: got %b, required 0", bus.o_Req_Ready); end
    if (bus.o_Busy !== 1'b0)     begin errors++; $display("FAIL blocked_busy: got %b, required 0", bus.o_Busy); end
    if (bus.o_TX_Byte !== 8'h00) begin errors++; $display("FAIL blocked_byte: got %h, required 00", bus.o_TX_Byte); end
    force_active = 1'b0;
    wait_idle("blocked");
  endtask

  task automatic test_watchdog();
    int n;
    apply_reset();
    no_done = 1'b1;
    tmo_cnt = 0;
    expect_tx(1, 8'h5C);
    push_req(1, 8'h5C, 1'b1);
    n = 0;
    while (tmo_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks += 5;
    if (tmo_cnt != 1) begin errors++; $display("FAIL wdog_pulses: got %0d, required 1", tmo_cnt); end
    if (tmo_cyc - last_dv_cyc != LIMIT) begin
      errors++; $display("FAIL wdog_latency: got %0d clocks, required %0d", tmo_cyc - last_dv_cyc, LIMIT);
    end
    if (bus.o_Busy !== 1'b0)     begin errors++; $display("FAIL wdog_busy: got %b, required 0", bus.o_Busy); end
    if (bus.o_Grant !== '0)      begin errors++; $display("FAIL wdog_grant: got %b, required 0", bus.o_Grant); end
    if (bus.o_TX_Byte !== 8'h5C) begin errors++; $display("FAIL wdog_hold: got %h, required 5c", bus.o_TX_Byte); end
    no_done = 1'b0;
    expect_tx(3, 8'h77);
    push_req(3, 8'h77, 1'b1);
    wait_idle("wdog_next");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int start;
    apply_reset();
    start = tx_count;
    expect_tx(2, 8'h99);
    push_req(2, 8'h99, 1'b1);
    n = 0;
    while (tx_count == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.o_Busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b, required 1", bus.o_Busy); end
    #2;
    rst_l = 1'b0;
    #1;
    checks += 4;
    if (bus.o_TX_DV !== 1'b0)    begin errors++; $display("FAIL midrst_dv: got %b, required 0", bus.o_TX_DV); end
    if (bus.o_Grant !== '0)      begin errors++; $display("FAIL midrst_grant: got %b, required 0", bus.o_Grant); end
    if (bus.o_Busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus.o_Busy); end
    if (bus.o_TX_Byte !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h, required 00", bus.o_TX_Byte); end
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      push_req(k, 8'hC0 + 8'(k), 1'b1);
      expect_tx(k, 8'hC0 + 8'(k));
    end
    wait_idle("midrst_after");
  endtask

  task automatic test_pkt_lock();
    apply_reset();
    expect_tx(0, 8'h11);
`ifdef UART_ARB_PKT_LOCK_EN
    expect_tx(0, 8'h22);
    expect_tx(1, 8'h33);
`else
    expect_tx(1, 8'h33);
    expect_tx(0, 8'h22);
`endif
    push_req(0, 8'h11, 1'b0);
    push_req(0, 8'h22, 1'b1);
    push_req(1, 8'h33, 1'b1);
    wait_idle("pkt_lock");
  endtask

  initial begin
    rst_l = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_ready_blocked();
    test_watchdog();
    test_reset_mid_frame();
    test_pkt_lock();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d launches missing, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
